// File: rtl/waveform_averager_if.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_averager_if
//  Description : Output stream bundle of the waveform averager: summed sample,
//                valid/ready handshake and end-of-record marker.
//  Revision    : 1.0  initial release
// ============================================================================
interface waveform_averager_if #(
  parameter int ACC_WIDTH = 16
);

  logic signed [ACC_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        dout_ready;
  logic                        dout_last;

  // Producer side (the averager)
  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  // Consumer side (output FIFO)
  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );

endinterface
`default_nettype wire

// File: rtl/waveform_averager.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_averager
//  Description : Triggered record averager. After each trigger it captures
//                RECORD_LEN samples (optionally minus the trigger-cycle
//                sample), sums them point-by-point into a record buffer over
//                a latched number of events, then streams the summed record
//                out over a valid/ready interface and re-arms.
//                Optional build macro WAVEFORM_AVERAGER_SATURATE_EN makes the
//                accumulate add saturate instead of wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module waveform_averager #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int RECORD_LEN = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int EVT_WIDTH  = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic signed [DATA_WIDTH-1:0] din,
  input  wire logic                         trig,
  input  wire logic        [EVT_WIDTH-1:0]  num_events,
  input  wire logic                         baseline_en,
  waveform_averager_if.master               outIf,
  output logic                              busy,
  output logic                              trig_dropped,
  output logic                              overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CAPTURE = 2'd1;
  localparam logic [1:0] c_NEXT    = 2'd2;  // last buffer write retires here
  localparam logic [1:0] c_DRAIN   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX   = ADDR_WIDTH'(RECORD_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   c_LEN_CNT    = (ADDR_WIDTH + 1)'(RECORD_LEN);
  localparam logic [ADDR_WIDTH:0]   c_LAST_CNT   = (ADDR_WIDTH + 1)'(RECORD_LEN - 1);
  localparam logic [EVT_WIDTH-1:0]  c_EVT_ONE    = EVT_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_nextState;

  // Batch bookkeeping
  logic [EVT_WIDTH-1:0]         r_evtCnt;
  logic [EVT_WIDTH-1:0]         r_target;
  logic                         r_blEn;
  logic signed [DATA_WIDTH-1:0] r_baseline;
  logic                         w_blEnEff;

  // Capture and write-back pipeline
  logic [ADDR_WIDTH-1:0]        r_capIdx;
  logic                         r_s1Valid;
  logic                         r_s1First;
  logic [ADDR_WIDTH-1:0]        r_s1Addr;
  logic signed [ACC_WIDTH-1:0]  r_s1Corr;
  logic signed [ACC_WIDTH-1:0]  w_dinExt;
  logic signed [ACC_WIDTH-1:0]  w_blExt;
  logic signed [ACC_WIDTH-1:0]  w_corr;
  logic signed [ACC_WIDTH-1:0]  w_rdData;
  logic signed [ACC_WIDTH-1:0]  w_sumWrap;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH-1:0]  w_wrData;
  logic                         w_addOvf;
  logic                         w_wrOvf;

  // Record buffer
  logic signed [ACC_WIDTH-1:0]  r_mem [0:RECORD_LEN-1];

  // Drain side
  logic [ADDR_WIDTH:0]          r_rdCnt;
  logic signed [ACC_WIDTH-1:0]  r_dout;
  logic                         r_doutValid;
  logic                         r_doutLast;
  logic                         w_xfer;
  logic                         w_load;

  // FSM-decoded controls
  logic                         w_trigAccept;
  logic                         w_capLast;
  logic                         w_batchDone;
  logic                         w_drainDone;

  logic                         r_overflow;
  logic                         r_trigDropped;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:    if (trig) w_nextState = c_CAPTURE;
      c_CAPTURE: if (r_capIdx == c_LAST_IDX) w_nextState = c_NEXT;
      c_NEXT:    w_nextState = (r_evtCnt >= r_target) ? c_DRAIN : c_IDLE;
      c_DRAIN:   if (r_doutValid && outIf.dout_ready && r_doutLast) w_nextState = c_IDLE;
      default:   w_nextState = c_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    busy         = 1'b0;
    w_trigAccept = 1'b0;
    w_capLast    = 1'b0;
    w_batchDone  = 1'b0;
    w_drainDone  = 1'b0;
    case (r_state)
      c_IDLE:    w_trigAccept = trig;
      c_CAPTURE: begin
        busy      = 1'b1;
        w_capLast = (r_capIdx == c_LAST_IDX);
      end
      c_NEXT: begin
        busy        = 1'b1;
        w_batchDone = (r_evtCnt >= r_target);
      end
      c_DRAIN: begin
        busy        = 1'b1;
        w_drainDone = r_doutValid && outIf.dout_ready && r_doutLast;
      end
      default: busy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Batch bookkeeping
  // --------------------------------------------------------------------------

  // The first trigger of a batch uses the live baseline_en; later ones the latched copy
  assign w_blEnEff = (r_evtCnt == '0) ? baseline_en : r_blEn;

  // Latch batch settings and per-event baseline; count completed events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evtCnt   <= '0;
      r_target   <= c_EVT_ONE;
      r_blEn     <= 1'b0;
      r_baseline <= '0;
    end else begin
      if (w_trigAccept) begin
        if (r_evtCnt == '0) begin
          r_target <= (num_events == '0) ? c_EVT_ONE : num_events;
          r_blEn   <= baseline_en;
        end
        r_baseline <= w_blEnEff ? din : '0;
      end
      if (w_capLast) begin
        r_evtCnt <= r_evtCnt + c_EVT_ONE;
      end else if (w_drainDone) begin
        r_evtCnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture and accumulate
  // --------------------------------------------------------------------------

  assign w_dinExt = ACC_WIDTH'(din);
  assign w_blExt  = ACC_WIDTH'(r_baseline);
  assign w_corr   = w_dinExt - w_blExt;

  // Stage 1: register the corrected sample with its buffer address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capIdx  <= '0;
      r_s1Valid <= 1'b0;
      r_s1First <= 1'b0;
      r_s1Addr  <= '0;
      r_s1Corr  <= '0;
    end else begin
      r_s1Valid <= (r_state == c_CAPTURE);
      r_s1First <= (r_evtCnt == '0);
      r_s1Addr  <= r_capIdx;
      r_s1Corr  <= w_corr;
      if (r_state == c_CAPTURE) begin
        r_capIdx <= r_capIdx + ADDR_WIDTH'(1);
      end else begin
        r_capIdx <= '0;
      end
    end
  end

  // Stage 2 read-add: addresses are strictly sequential so the location read
  // here was last written a full record earlier and is never in flight.
  assign w_rdData  = r_mem[r_s1Addr];
  assign w_sumWrap = w_rdData + r_s1Corr;
  assign w_addOvf  = (w_rdData[ACC_WIDTH-1] == r_s1Corr[ACC_WIDTH-1]) &&
                     (w_sumWrap[ACC_WIDTH-1] != w_rdData[ACC_WIDTH-1]);
`ifdef WAVEFORM_AVERAGER_SATURATE_EN
  assign w_sum     = w_addOvf ? (w_rdData[ACC_WIDTH-1] ? c_ACC_MIN : c_ACC_MAX) : w_sumWrap;
`else
  assign w_sum     = w_sumWrap;
`endif
  // The first event of a batch overwrites whatever the buffer held
  assign w_wrData  = r_s1First ? r_s1Corr : w_sum;
  assign w_wrOvf   = r_s1Valid && !r_s1First && w_addOvf;

  // Stage 2 write into the record buffer (contents are don't-care after reset)
  always_ff @(posedge clk) begin
    if (r_s1Valid) begin
      r_mem[r_s1Addr] <= w_wrData;
    end
  end

  // Sticky overflow, cleared once the summed record has fully drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drainDone) begin
      r_overflow <= 1'b0;
    end else if (w_wrOvf) begin
      r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Drain
  // --------------------------------------------------------------------------

  assign w_xfer = r_doutValid && outIf.dout_ready;
  // Refill the output register when it is empty or being taken this cycle
  assign w_load = (r_state == c_DRAIN) && (r_rdCnt < c_LEN_CNT) &&
                  (!r_doutValid || outIf.dout_ready);

  // Registered output word; held steady while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdCnt     <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_doutLast  <= 1'b0;
    end else begin
      if (r_state != c_DRAIN) begin
        r_rdCnt <= '0;
      end else if (w_load) begin
        r_rdCnt <= r_rdCnt + (ADDR_WIDTH + 1)'(1);
      end
      if (w_load) begin
        r_dout      <= r_mem[r_rdCnt[ADDR_WIDTH-1:0]];
        r_doutValid <= 1'b1;
        r_doutLast  <= (r_rdCnt == c_LAST_CNT);
      end else if (w_xfer) begin
        r_doutValid <= 1'b0;
        r_doutLast  <= 1'b0;
      end
    end
  end

  // One-cycle flag for a trigger that arrived while not armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trigDropped <= 1'b0;
    end else begin
      r_trigDropped <= trig && (r_state != c_IDLE);
    end
  end

  assign outIf.dout       = r_dout;
  assign outIf.dout_valid = r_doutValid;
  assign outIf.dout_last  = r_doutLast;
  assign trig_dropped     = r_trigDropped;
  assign overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_waveform_averager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_waveform_averager
//  Description : Scoreboard bench for waveform_averager. A 16-bit instance
//                runs all scenarios; an 8-bit instance is enabled only for
//                the accumulate-overflow scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_waveform_averager;

  localparam int DW  = 8;
  localparam int RL  = 8;
  localparam int ADW = 3;
  localparam int EW  = 8;

  typedef struct {
    longint data;
    bit     last;
    bit     ovf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic                 trig;
  logic                 en8;
  logic                 trig8;
  logic [EW-1:0]        numEvents;
  logic                 baselineEn;
  logic                 doutReady;
  logic                 busy16, drop16, ovf16;
  logic                 busy8, drop8, ovf8;

  waveform_averager_if #(.ACC_WIDTH(16)) if16 ();
  waveform_averager_if #(.ACC_WIDTH(8))  if8  ();

  assign trig8           = trig & en8;
  assign if16.dout_ready = doutReady;
  assign if8.dout_ready  = doutReady;

  waveform_averager #(
    .DATA_WIDTH(DW), .ACC_WIDTH(16), .RECORD_LEN(RL), .ADDR_WIDTH(ADW), .EVT_WIDTH(EW)
  ) dut16 (
    .clk(clk), .rst(rst), .din(din), .trig(trig), .num_events(numEvents),
    .baseline_en(baselineEn), .outIf(if16), .busy(busy16),
    .trig_dropped(drop16), .overflow(ovf16)
  );

  waveform_averager #(
    .DATA_WIDTH(DW), .ACC_WIDTH(8), .RECORD_LEN(RL), .ADDR_WIDTH(ADW), .EVT_WIDTH(EW)
  ) dut8 (
    .clk(clk), .rst(rst), .din(din), .trig(trig8), .num_events(numEvents),
    .baseline_en(baselineEn), .outIf(if8), .busy(busy8),
    .trig_dropped(drop8), .overflow(ovf8)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q8[$];
  bit   readyPat[$];
  bit   readyRand = 1'b0;
  int   dropTotal = 0;

  // Reference model state, index 0 = 16-bit instance, 1 = 8-bit instance
  int     mEvt[2];
  int     mTarget[2];
  bit     mBl[2];
  bit     mOvf[2];
  longint mAcc[2][RL];
  longint evtBuf[RL+1];   // [0] = trigger-cycle sample, [1..RL] = record

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void failNow(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endfunction

  function automatic longint wrapTo(longint v, int w);
    longint m = longint'(1) << w;
    longint r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  // One event of the averaging rule, in plain integer arithmetic
  function automatic void modelEvent(int d, bit blIn, int neIn);
    int     w    = (d == 0) ? 16 : 8;
    longint hi   = (longint'(1) << (w - 1)) - 1;
    longint lo   = -(longint'(1) << (w - 1));
    longint base;
    longint c;
    longint s;
    exp_t   e;
    if (mEvt[d] == 0) begin
      mTarget[d] = (neIn == 0) ? 1 : neIn;
      mBl[d]     = blIn;
    end
    base = mBl[d] ? evtBuf[0] : 0;
    for (int i = 0; i < RL; i++) begin
      c = wrapTo(evtBuf[i+1] - base, w);
      if (mEvt[d] == 0) begin
        mAcc[d][i] = c;
      end else begin
        s = mAcc[d][i] + c;
        if (s > hi || s < lo) begin
          mOvf[d] = 1'b1;
`ifdef WAVEFORM_AVERAGER_SATURATE_EN
          s = (s > hi) ? hi : lo;
`else
          s = wrapTo(s, w);
`endif
        end
        mAcc[d][i] = s;
      end
    end
    mEvt[d]++;
    if (mEvt[d] >= mTarget[d]) begin
      for (int i = 0; i < RL; i++) begin
        e.data = mAcc[d][i];
        e.last = (i == RL - 1);
        e.ovf  = mOvf[d];
        if (d == 0) q16.push_back(e);
        else        q8.push_back(e);
      end
      mEvt[d] = 0;
      mOvf[d] = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      mEvt[d] = 0;
      mOvf[d] = 1'b0;
    end
  endfunction

  // Advance one clock; inputs change just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (readyPat.size() > 0) doutReady = readyPat.pop_front();
    else if (readyRand)      doutReady = 1'($urandom_range(0, 1));
    else                     doutReady = 1'b1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy16 || busy8) begin
      tick();
      n++;
      if (n > 3000) begin
        failNow("wait_idle");
        break;
      end
    end
  endtask

  task automatic fillConst(int v);
    for (int k = 0; k <= RL; k++) evtBuf[k] = v;
  endtask

  task automatic fillRandom();
    for (int k = 0; k <= RL; k++) evtBuf[k] = longint'($urandom_range(0, 255)) - 128;
  endtask

  task automatic doEvent(bit bl, int ne);
    waitIdle();
    trig       = 1'b1;
    din        = DW'(evtBuf[0]);
    baselineEn = bl;
    numEvents  = EW'(ne);
    tick();
    trig = 1'b0;
    for (int k = 1; k <= RL; k++) begin
      din = DW'(evtBuf[k]);
      tick();
    end
    // scramble batch settings mid-batch; they must have no effect
    din        = DW'($urandom);
    baselineEn = 1'($urandom);
    numEvents  = EW'($urandom);
    modelEvent(0, bl, ne);
    if (en8) modelEvent(1, bl, ne);
  endtask

  // Monitor: pop and compare on each transfer, and check stall stability
  logic signed [15:0] prevDout16;
  logic signed [7:0]  prevDout8;
  bit prevValid16 = 1'b0, prevValid8 = 1'b0, prevReady = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    if (rst) begin
      prevValid16 = 1'b0;
      prevValid8  = 1'b0;
    end else begin
      if (prevValid16 && !prevReady) begin
        chk("stall_valid16", longint'(if16.dout_valid), 1);
        chk("stall_data16", longint'(if16.dout), longint'(prevDout16));
      end
      if (prevValid8 && !prevReady) begin
        chk("stall_valid8", longint'(if8.dout_valid), 1);
        chk("stall_data8", longint'(if8.dout), longint'(prevDout8));
      end
      if (if16.dout_valid && if16.dout_ready) begin
        if (q16.size() == 0) failNow("unexpected_word16");
        else begin
          me = q16.pop_front();
          chk("dout16", longint'(if16.dout), me.data);
          chk("last16", longint'(if16.dout_last), longint'(me.last));
          chk("ovf16", longint'(ovf16), longint'(me.ovf));
        end
      end
      if (if8.dout_valid && if8.dout_ready) begin
        if (q8.size() == 0) failNow("unexpected_word8");
        else begin
          me = q8.pop_front();
          chk("dout8", longint'(if8.dout), me.data);
          chk("last8", longint'(if8.dout_last), longint'(me.last));
          chk("ovf8", longint'(ovf8), longint'(me.ovf));
        end
      end
      if (drop16) dropTotal++;
      prevValid16 = if16.dout_valid;
      prevValid8  = if8.dout_valid;
      prevReady   = doutReady;
      prevDout16  = if16.dout;
      prevDout8   = if8.dout;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dropBase;
    int n;
    int ne;
    bit bl;
    rst = 1'b1; trig = 1'b0; din = '0; baselineEn = 1'b0; numEvents = '0;
    en8 = 1'b0; doutReady = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dout", longint'(if16.dout), 0);
    chk("rst_valid", longint'(if16.dout_valid), 0);
    chk("rst_last", longint'(if16.dout_last), 0);
    chk("rst_busy", longint'(busy16), 0);
    chk("rst_drop", longint'(drop16), 0);
    chk("rst_ovf", longint'(ovf16), 0);

    // Three events of constant 5 -> 15 per word
    fillConst(5);
    for (int e = 0; e < 3; e++) doEvent(1'b0, 3);
    waitIdle();
    tick();
    chk("busy_after_drain", longint'(busy16), 0);
    chk("drain_complete", q16.size(), 0);

    // Baseline subtraction: trigger sample 10, ramp 11..18 -> 1..8
    for (int k = 0; k <= RL; k++) evtBuf[k] = 10 + k;
    doEvent(1'b1, 1);
    waitIdle();

    // Repeat of the first case with a stalled drain and a dropped trigger
    fillConst(5);
    for (int e = 0; e < 3; e++) doEvent(1'b0, 3);
    n = 0;
    while (!if16.dout_valid) begin
      tick();
      n++;
      if (n > 50) begin
        failNow("drain_start");
        break;
      end
    end
    dropBase = dropTotal;
    readyPat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    trig = 1'b1;
    tick();
    trig = 1'b0;
    waitIdle();
    tick();
    chk("trig_dropped_pulses", dropTotal - dropBase, 1);
    chk("stall_drain_complete", q16.size(), 0);

    // Accumulate overflow on the narrow instance
    en8 = 1'b1;
    fillConst(100);
    doEvent(1'b0, 2);
    doEvent(1'b0, 2);
    waitIdle();
    tick();
    chk("ovf8_cleared", longint'(ovf8), 0);
    chk("ovf8_drain_complete", q8.size(), 0);
    en8 = 1'b0;

    // Reset during the second event of a two-event batch
    fillRandom();
    doEvent(1'b0, 2);
    waitIdle();
    fillRandom();
    trig = 1'b1; din = DW'(evtBuf[0]); numEvents = EW'(2);
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      din = DW'(evtBuf[k]);
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelReset();
    chk("abort_busy", longint'(busy16), 0);
    chk("abort_valid", longint'(if16.dout_valid), 0);
    fillConst(-3);
    doEvent(1'b0, 1);
    waitIdle();

    // Zero event count behaves as one
    fillConst(7);
    doEvent(1'b0, 0);
    waitIdle();

    // Randomized batches with random backpressure and mid-batch setting changes
    readyRand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ne = $urandom_range(0, 3);
      bl = 1'($urandom);
      for (int e = 0; e < ((ne == 0) ? 1 : ne); e++) begin
        fillRandom();
        if (e == 0) doEvent(bl, ne);
        else        doEvent(1'($urandom), $urandom_range(0, 5));
      end
    end
    waitIdle();
    readyRand = 1'b0;
    repeat (3) tick();
    chk("final_q16_empty", q16.size(), 0);
    chk("final_q8_empty", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
